// File: rtl/conv3x3_if.sv
// Signal bundle for conv3x3_engine: control/config inputs, frame-memory read port,
// result-memory write port and status. The engine takes the master side.
interface conv3x3_if #(
  parameter int XW    = 7,
  parameter int YW    = 7,
  parameter int PIX_W = 8,
  parameter int OUT_W = 8
);
  logic                 start;
  logic                 k_we;
  logic [3:0]           k_idx;
  logic [15:0]          k_data;
  logic                 rd_req;
  logic [XW+YW-1:0]     rd_addr;
  logic [PIX_W-1:0]     rd_data;
  logic                 wr_req;
  logic [XW+YW-1:0]     wr_addr;
  logic [OUT_W-1:0]     wr_data;
  logic                 wr_ack;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, k_we, k_idx, k_data, rd_data, wr_ack,
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, busy, done
  );

  modport slave (
    output start, k_we, k_idx, k_data, rd_data, wr_ack,
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/conv3x3_engine.sv
// 3x3 convolution over a 2^XW x 2^YW image: loadable signed kernel, bias, arithmetic
// shift and clamp; one tap read per cycle, one handshaked write per pixel.
module conv3x3_engine #(
  parameter int XW     = 7,
  parameter int YW     = 7,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 4,
  parameter int OUT_W  = 8
) (
  input  logic      clk,
  input  logic      reset,
  conv3x3_if.master bus
);
  localparam int AW    = XW + YW;
  localparam int ACC_W = PIX_W + COEF_W + 4;
  localparam int SUM_W = ((ACC_W > 16) ? ACC_W : 16) + 2;
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((1 << OUT_W) - 1);

  typedef enum logic [2:0] {IDLE, TAP, TAIL, WRITE, FIN} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                t_q, t_d;
  logic [XW-1:0]             x_q, x_d;
  logic [YW-1:0]             y_q, y_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      pend_q;

  logic signed [COEF_W-1:0]  coef_q [9];
  logic signed [15:0]        bias_q;
  logic [3:0]                shift_q;

  logic                      rd_req_q, rd_req_d;
  logic [AW-1:0]             rd_addr_q, rd_addr_d;
  logic                      wr_req_q, wr_req_d;
  logic [AW-1:0]             wr_addr_q, wr_addr_d;
  logic [OUT_W-1:0]          wr_data_q, wr_data_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [3:0]                pidx;
  logic signed [ACC_W-1:0]   pix_ext, coef_ext, prod, acc_sum;
  logic signed [SUM_W-1:0]   biased, shifted;
  logic [OUT_W-1:0]          clamped;
  logic [1:0]                row, col;
  logic                      x_ok, y_ok, last_px;
  logic [XW-1:0]             nx;
  logic [YW-1:0]             ny;

  // Tap t -> {row, col} of the 3x3 window, raster order, centre at t=4.
  function automatic logic [3:0] tap_rc(input logic [3:0] t);
    logic [3:0] rc;
    case (t)
      4'd0:    rc = 4'b00_00;
      4'd1:    rc = 4'b00_01;
      4'd2:    rc = 4'b00_10;
      4'd3:    rc = 4'b01_00;
      4'd4:    rc = 4'b01_01;
      4'd5:    rc = 4'b01_10;
      4'd6:    rc = 4'b10_00;
      4'd7:    rc = 4'b10_01;
      default: rc = 4'b10_10;
    endcase
    return rc;
  endfunction

  // Datapath: data for the tap issued last cycle is on rd_data now.
  always_comb begin
    pidx     = (state_q == TAIL) ? 4'd8 : ((t_q == 4'd0) ? 4'd0 : t_q - 4'd1);
    pix_ext  = ACC_W'($signed({1'b0, bus.rd_data}));
    coef_ext = ACC_W'(coef_q[pidx]);
    prod     = '0;
    if (pend_q) prod = pix_ext * coef_ext;
    acc_sum  = acc_q + prod;
    biased   = SUM_W'(acc_sum) + SUM_W'(bias_q);
    shifted  = biased >>> shift_q;
    if (shifted < 0)           clamped = '0;
    else if (shifted > SAT_HI) clamped = '1;
    else                       clamped = shifted[OUT_W-1:0];
  end

  assign last_px = (x_q == '1) && (y_q == '1);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    t_d       = t_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    wr_data_d = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = TAP;
          t_d     = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      TAP: begin
        acc_d = (t_q == 4'd0) ? '0 : acc_sum;
        if (t_q == 4'd8) state_d = TAIL;
        else             t_d     = t_q + 4'd1;
      end
      TAIL: begin
        state_d   = WRITE;
        wr_data_d = clamped;
      end
      WRITE: begin
        wr_data_d = wr_data_q;
        if (bus.wr_ack) begin
          wr_data_d = '0;
          if (last_px) begin
            state_d = FIN;
          end else begin
            state_d = TAP;
            t_d     = '0;
            if (x_q == '1) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-cycle state.
    {row, col} = tap_rc(t_d);
    x_ok       = !((col == 2'd0 && x_d == '0) || (col == 2'd2 && x_d == '1));
    y_ok       = !((row == 2'd0 && y_d == '0) || (row == 2'd2 && y_d == '1));
    nx         = x_d + XW'(col) - XW'(1);
    ny         = y_d + YW'(row) - YW'(1);
    rd_req_d   = (state_d == TAP) && x_ok && y_ok;
    rd_addr_d  = rd_req_d ? {ny, nx} : '0;
    wr_req_d   = (state_d == WRITE);
    wr_addr_d  = wr_req_d ? {y_d, x_d} : '0;
    busy_d     = state_d inside {TAP, TAIL, WRITE};
    done_d     = (state_d == FIN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      t_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      pend_q    <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      // NOTE: the kernel array is configuration, not bulk storage, so it is reset to the Laplacian.
      for (int i = 0; i < 9; i++) coef_q[i] <= (i == 4) ? COEF_W'(-8) : COEF_W'(1);
      bias_q    <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      x_q       <= x_d;
      y_q       <= y_d;
      acc_q     <= acc_d;
      pend_q    <= rd_req_q;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      // Config only moves while idle, so a frame always sees the set present at start.
      if (state_q == IDLE && bus.k_we) begin
        if (bus.k_idx < 4'd9)       coef_q[bus.k_idx] <= bus.k_data[COEF_W-1:0];
        else if (bus.k_idx == 4'd9)  bias_q            <= bus.k_data;
        else if (bus.k_idx == 4'd10) shift_q           <= bus.k_data[3:0];
      end
    end
  end

  assign bus.rd_req  = rd_req_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_req  = wr_req_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine on a 4x4 image: scenario and expected-pixel tables,
// plus hand sequences for write stall, mid-frame start/k_we and mid-frame reset.
module tb_conv3x3_engine;
  localparam int XW = 2, YW = 2, PIX_W = 8, COEF_W = 4, OUT_W = 8;
  localparam int AW = XW + YW;
  localparam int NPIX = 1 << AW;
  localparam int FRAME_CYC = 11 * NPIX + 1;

  typedef enum int {IMG_ZERO, IMG_DOT, IMG_ONES, IMG_FULL} img_e;
  typedef enum int {K_KEEP, K_ONES} kern_e;
  typedef struct { string name; img_e img; kern_e kern; int bias; int shift; } scen_t;
  typedef struct { int scen; int x; int y; int exp; } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv3x3_if #(.XW(XW), .YW(YW), .PIX_W(PIX_W), .OUT_W(OUT_W)) bus ();
  conv3x3_engine #(.XW(XW), .YW(YW), .PIX_W(PIX_W), .COEF_W(COEF_W), .OUT_W(OUT_W))
    dut (.clk(clk), .reset(reset), .bus(bus.master));

  logic [PIX_W-1:0] img [NPIX];
  int out_img [NPIX];
  int px_reads [NPIX];
  int n_chk = 0, n_err = 0;

  // Monitor-owned counters (cumulative); the test reads deltas.
  int rd_cnt = 0, wr_cnt = 0, wr_seq = 0, cur_reads = 0;
  int order_err = 0, proto_err = 0, stall_cnt = 0, unstable_err = 0;
  int stall_total = 0;
  int stall_addr = 3;
  logic prev_wr_req = 1'b0;
  logic [AW-1:0] held_addr = '0;
  logic [OUT_W-1:0] held_data = '0;

  // Frame memory: data valid the cycle after the request; garbage otherwise.
  always @(posedge clk) bus.rd_data <= bus.rd_req ? img[bus.rd_addr] : 8'hEE;

  // Write acknowledge driver and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.wr_req && int'(bus.wr_addr) == stall_addr && stall_cnt < stall_total) bus.wr_ack = 1'b0;
    else bus.wr_ack = 1'b1;
    if (reset) begin
      wr_seq = 0;
      cur_reads = 0;
    end
    if (bus.rd_req) begin
      rd_cnt++;
      cur_reads++;
    end
    if (bus.rd_req && bus.wr_req) proto_err++;
    if ((bus.rd_req || bus.wr_req) && !bus.busy) proto_err++;
    if (bus.wr_req && !prev_wr_req) begin
      held_addr = bus.wr_addr;
      held_data = bus.wr_data;
    end
    if (bus.wr_req && (bus.wr_addr != held_addr || bus.wr_data != held_data)) unstable_err++;
    if (bus.wr_req && !bus.wr_ack) stall_cnt++;
    if (bus.wr_req && bus.wr_ack) begin
      out_img[bus.wr_addr] = int'(bus.wr_data);
      px_reads[bus.wr_addr] = cur_reads;
      cur_reads = 0;
      if (int'(bus.wr_addr) != wr_seq) order_err++;
      wr_seq = (wr_seq + 1) % NPIX;
      wr_cnt++;
    end
    prev_wr_req = bus.wr_req;
  end

  task automatic check(input string name, input int actual, input int expected);
    n_chk++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [15:0] data);
    @(negedge clk);
    bus.k_we = 1'b1;
    bus.k_idx = idx;
    bus.k_data = data;
    @(negedge clk);
    bus.k_we = 1'b0;
  endtask

  task automatic load_ones_kernel(input int bias, input int shift);
    for (int i = 0; i < 9; i++) cfg_write(4'(i), 16'hFFF1);
    cfg_write(4'd12, 16'h7FFF);
    cfg_write(4'd9, 16'(bias));
    cfg_write(4'd10, 16'(shift));
  endtask

  task automatic fill_img(input img_e kind);
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        IMG_ZERO: img[i] = 8'd0;
        IMG_DOT:  img[i] = (i == 5) ? 8'd10 : 8'd0;
        IMG_ONES: img[i] = 8'd1;
        default:  img[i] = 8'd255;
      endcase
    end
  endtask

  // Starts a frame and waits (bounded) for done; optionally pokes start+k_we mid-frame.
  task automatic run_frame(input int poke_at, output int cycles, output bit ok, output bit busy1);
    @(negedge clk);
    bus.start = 1'b1;
    cycles = 0;
    ok = 1'b0;
    busy1 = 1'b0;
    while (!ok && cycles < 3000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      bus.start = (cycles == poke_at);
      bus.k_we = (cycles == poke_at);
      bus.k_idx = 4'd10;
      bus.k_data = 16'd0;
      if (cycles == 1) busy1 = bus.busy;
      if (bus.done) ok = 1'b1;
    end
    bus.start = 1'b0;
    bus.k_we = 1'b0;
  endtask

  scen_t scen [7];
  vec_t vecs [$];

  initial begin
    int cyc, rd0, wr0, st0;
    bit ok, busy1;

    scen[0] = '{"zero", IMG_ZERO, K_KEEP, 0, 0};
    scen[1] = '{"dot",  IMG_DOT,  K_KEEP, 0, 0};
    scen[2] = '{"ones", IMG_ONES, K_KEEP, 0, 0};
    scen[3] = '{"sat0", IMG_FULL, K_ONES, 0, 0};
    scen[4] = '{"sat3", IMG_FULL, K_ONES, 0, 3};
    scen[5] = '{"sat4", IMG_FULL, K_ONES, 0, 4};
    scen[6] = '{"bias", IMG_FULL, K_ONES, -2000, 1};
    vecs = '{
      '{0, 0, 0, 0},   '{0, 2, 1, 0},   '{0, 3, 3, 0},
      '{1, 1, 1, 0},   '{1, 0, 0, 10},  '{1, 1, 0, 10},  '{1, 2, 0, 10},
      '{1, 0, 1, 10},  '{1, 2, 1, 10},  '{1, 0, 2, 10},  '{1, 2, 2, 10},
      '{1, 3, 3, 0},   '{1, 3, 1, 0},   '{1, 1, 3, 0},
      '{2, 0, 0, 0},   '{2, 1, 0, 0},   '{2, 1, 1, 0},   '{2, 3, 3, 0},
      '{3, 1, 1, 255}, '{3, 0, 0, 255}, '{3, 3, 2, 255},
      '{4, 1, 1, 255}, '{4, 0, 0, 127}, '{4, 1, 0, 191},
      '{5, 1, 1, 143}, '{5, 0, 0, 63},  '{5, 1, 0, 95},  '{5, 3, 2, 95},
      '{6, 2, 2, 147}, '{6, 2, 1, 147}, '{6, 0, 0, 0},   '{6, 1, 0, 0}
    };

    bus.start = 1'b0;
    bus.k_we = 1'b0;
    bus.k_idx = '0;
    bus.k_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_rd_req", int'(bus.rd_req), 0);
    check("reset_wr_req", int'(bus.wr_req), 0);
    check("reset_rd_addr", int'(bus.rd_addr), 0);
    check("reset_wr_data", int'(bus.wr_data), 0);
    reset = 1'b0;

    for (int s = 0; s < 7; s++) begin
      fill_img(scen[s].img);
      if (scen[s].kern == K_ONES) load_ones_kernel(scen[s].bias, scen[s].shift);
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      run_frame(-1, cyc, ok, busy1);
      check({scen[s].name, "_done"}, int'(ok), 1);
      check({scen[s].name, "_busy_rise"}, int'(busy1), 1);
      check({scen[s].name, "_cycles"}, cyc, FRAME_CYC);
      check({scen[s].name, "_busy_at_done"}, int'(bus.busy), 0);
      check({scen[s].name, "_writes"}, wr_cnt - wr0, NPIX);
      check({scen[s].name, "_reads"}, rd_cnt - rd0, 100);
      @(negedge clk);
      check({scen[s].name, "_done_pulse"}, int'(bus.done), 0);
      foreach (vecs[v]) begin
        if (vecs[v].scen == s)
          check($sformatf("%s_px_%0d_%0d", scen[s].name, vecs[v].x, vecs[v].y),
                out_img[vecs[v].y * 4 + vecs[v].x], vecs[v].exp);
      end
    end
    check("reads_corner", px_reads[0], 4);
    check("reads_edge", px_reads[1], 6);
    check("reads_interior", px_reads[5], 9);

    // Write stall on pixel 3: five cycles with wr_ack low.
    fill_img(IMG_FULL);
    load_ones_kernel(0, 4);
    st0 = stall_cnt;
    wr0 = wr_cnt;
    stall_total = stall_cnt + 5;
    run_frame(-1, cyc, ok, busy1);
    check("stall_done", int'(ok), 1);
    check("stall_cycles", cyc, FRAME_CYC + 5);
    check("stall_len", stall_cnt - st0, 5);
    check("stall_writes", wr_cnt - wr0, NPIX);
    check("stall_px3", out_img[3], 63);
    check("stall_px5", out_img[5], 143);

    // start and a shift write mid-frame must both be ignored.
    run_frame(40, cyc, ok, busy1);
    check("poke_done", int'(ok), 1);
    check("poke_cycles", cyc, FRAME_CYC);
    check("poke_px5", out_img[5], 143);
    @(negedge clk);
    check("poke_no_restart", int'(bus.busy), 0);
    run_frame(-1, cyc, ok, busy1);
    check("poke_cfg_kept", out_img[0], 63);

    // Reset mid-frame: idle next cycle, config back to the Laplacian.
    fill_img(IMG_DOT);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", int'(bus.busy), 0);
    check("rst_mid_rd_req", int'(bus.rd_req), 0);
    check("rst_mid_wr_req", int'(bus.wr_req), 0);
    check("rst_mid_wr_addr", int'(bus.wr_addr), 0);
    reset = 1'b0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    repeat (10) @(negedge clk);
    check("rst_quiet_reads", rd_cnt - rd0, 0);
    check("rst_quiet_writes", wr_cnt - wr0, 0);
    run_frame(-1, cyc, ok, busy1);
    check("rst_frame_done", int'(ok), 1);
    check("rst_lap_centre", out_img[5], 0);
    check("rst_lap_nbr", out_img[0], 10);
    check("rst_lap_far", out_img[15], 0);

    check("write_order", order_err, 0);
    check("protocol", proto_err, 0);
    check("wr_stable", unstable_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
